// File: rtl/wide_add_sequencer_pkg.sv
// Shared types and constants for the byte-serial wide adder.
package wide_add_sequencer_pkg;

  localparam int unsigned ByteW = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/wide_add_sequencer_if.sv
// Request/result bundle between the control unit (master) and the sequencer (slave).
interface wide_add_sequencer_if #(
  parameter int unsigned NBYTES = 4
);
  import wide_add_sequencer_pkg::*;

  localparam int unsigned W = ByteW * NBYTES;

  logic         start;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  modport master (
    output start, op_sub, a, b,
    input  busy, done, result, carry_out, overflow
  );

  modport slave (
    input  start, op_sub, a, b,
    output busy, done, result, carry_out, overflow
  );

endinterface

// File: rtl/byte_add_slice.sv
// Combinational 8-bit adder slice with carry in/out.
module byte_add_slice
  import wide_add_sequencer_pkg::*;
(
  input  logic [ByteW-1:0] a,
  input  logic [ByteW-1:0] b,
  input  logic             cin,
  output logic [ByteW-1:0] s,
  output logic             cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{ByteW{1'b0}}, cin};

endmodule

// File: rtl/wide_add_sequencer.sv
// NBYTES-wide add/subtract performed one byte per clock, LSB first, through one shared slice.
module wide_add_sequencer
  import wide_add_sequencer_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  wide_add_sequencer_if.slave   bus
);

  localparam int unsigned W    = ByteW * NBYTES;
  localparam int unsigned IdxW = $clog2(NBYTES);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [W-1:0]      op_a_q, op_a_d;
  logic [W-1:0]      op_b_q, op_b_d;
  logic [W-1:0]      result_q, result_d;
  logic              carry_out_q, carry_out_d;
  logic              overflow_q, overflow_d;

  int unsigned       base;
  logic [ByteW-1:0]  sum;
  logic              sum_cout;
  logic              idx_last;

  assign base     = ByteW * 32'(idx_q);
  assign idx_last = (idx_q == IdxW'(NBYTES - 1));

  byte_add_slice u_slice (
    .a    (op_a_q[base +: ByteW]),
    .b    (op_b_q[base +: ByteW]),
    .cin  (carry_q),
    .s    (sum),
    .cout (sum_cout)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          // Subtraction as A + ~B + 1: invert B here and seed the carry with 1.
          op_a_d      = bus.a;
          op_b_d      = bus.op_sub ? ~bus.b : bus.b;
          carry_d     = bus.op_sub;
          idx_d       = '0;
          result_d    = '0;
          carry_out_d = 1'b0;
          overflow_d  = 1'b0;
          state_d     = StRun;
        end
      end
      StRun: begin
        result_d[base +: ByteW] = sum;
        carry_d                 = sum_cout;
        idx_d                   = idx_q + IdxW'(1);
        if (idx_last) begin
          idx_d       = '0;
          carry_out_d = sum_cout;
          overflow_d  = (op_a_q[W-1] == op_b_q[W-1]) && (sum[ByteW-1] != op_a_q[W-1]);
          state_d     = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.busy      = (state_q == StRun);
  assign bus.done      = (state_q == StDone);
  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench: vector table plus handshake/reset sequences, scoreboard on done.
module tb_wide_add_sequencer;

  localparam int unsigned NBYTES = 4;
  localparam int unsigned W      = 8 * NBYTES;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  wide_add_sequencer_if #(.NBYTES(NBYTES)) bus ();

  wide_add_sequencer #(.NBYTES(NBYTES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         v;
  } exp_t;

  typedef struct {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         e;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[8];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_done = 0;
  int   n_exp_done = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] r, input logic c, input logic v);
    vec_t t;
    t.sub = sub; t.a = a; t.b = b;
    t.e.r = r; t.e.c = c; t.e.v = v;
    return t;
  endfunction

  // Full-width reference for random operands.
  function automatic exp_t model(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] bb;
    logic [W:0]   s;
    exp_t         e;
    bb  = sub ? ~b : b;
    s   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
    e.r = s[W-1:0];
    e.c = s[W];
    e.v = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      n_done++;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected_done: got done=1, expected no pending op");
      end else begin
        mon_e = sb_q.pop_front();
        check("result", bus.result, mon_e.r);
        check("carry_out", 32'(bus.carry_out), 32'(mon_e.c));
        check("overflow", 32'(bus.overflow), 32'(mon_e.v));
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, " busy"}, 32'(bus.busy), 32'd0);
    check({tag, " done"}, 32'(bus.done), 32'd0);
    check({tag, " result"}, bus.result, 32'd0);
    check({tag, " carry_out"}, 32'(bus.carry_out), 32'd0);
    check({tag, " overflow"}, 32'(bus.overflow), 32'd0);
  endtask

  // Wait (bounded) until done; returns edges seen after the accept edge and busy cycles.
  task automatic wait_done(input bit disturb, input logic sub, output int n, output int busy_cyc);
    n = 0;
    busy_cyc = bus.busy ? 1 : 0;
    while (!bus.done && n < 20) begin
      if (disturb) begin
        bus.start  = 1'b1;
        bus.op_sub = ~sub;
        bus.a      = $urandom;
        bus.b      = $urandom;
      end
      @(posedge clk); #1;
      n++;
      if (bus.busy) busy_cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic sub, input logic [W-1:0] a,
                        input logic [W-1:0] b, input exp_t e, input bit disturb);
    int n;
    int busy_cyc;
    bus.start  = 1'b1;
    bus.op_sub = sub;
    bus.a      = a;
    bus.b      = b;
    sb_q.push_back(e);
    n_exp_done++;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(disturb, sub, n, busy_cyc);
    check({tag, " latency"}, 32'(n), 32'(NBYTES));
    check({tag, " busy_cycles"}, 32'(busy_cyc), 32'(NBYTES));
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, " idle_done"}, 32'(bus.done), 32'd0);
    check({tag, " idle_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int   n;
    int   busy_cyc;
    logic rs;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    vecs[0] = mk(1'b0, 32'h0000_00AA, 32'h0000_0054, 32'h0000_00FE, 1'b0, 1'b0);
    vecs[1] = mk(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
    vecs[2] = mk(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
    vecs[3] = mk(1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
    vecs[4] = mk(1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1);
    vecs[5] = mk(1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0);
    vecs[6] = mk(1'b1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0);
    vecs[7] = mk(1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1);

    // Reset held with start and random operands toggling.
    bus.start = 1'b0; bus.op_sub = 1'b0; bus.a = '0; bus.b = '0;
    for (int i = 0; i < 3; i++) begin
      bus.start  = 1'b1;
      bus.op_sub = 1'($urandom);
      bus.a      = $urandom;
      bus.b      = $urandom;
      @(posedge clk); #1;
      check_zero("reset");
    end
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_busy", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].e, 1'b0);
    end

    // Random operands, with start/operand disturbance on alternate ops.
    for (int i = 0; i < 4; i++) begin
      rs = 1'($urandom);
      ra = $urandom;
      rb = $urandom;
      run_op($sformatf("rand%0d", i), rs, ra, rb, model(rs, ra, rb), i[0]);
    end

    // Back-to-back: start held high, operands switched to op2 right after acceptance.
    bus.start = 1'b1; bus.op_sub = 1'b0; bus.a = 32'h0F0F_0F0F; bus.b = 32'h0101_0101;
    sb_q.push_back('{r: 32'h1010_1010, c: 1'b0, v: 1'b0});
    sb_q.push_back('{r: 32'hFFFF_FFF0, c: 1'b0, v: 1'b0});
    n_exp_done += 2;
    @(posedge clk); #1;
    bus.op_sub = 1'b1; bus.a = 32'h0000_0010; bus.b = 32'h0000_0020;
    wait_done(1'b0, 1'b0, n, busy_cyc);
    check("b2b op1 latency", 32'(n), 32'(NBYTES));
    @(posedge clk); #1;
    check("b2b idle busy", 32'(bus.busy), 32'd0);
    check("b2b idle done", 32'(bus.done), 32'd0);
    @(posedge clk); #1;
    check("b2b op2 accepted", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    wait_done(1'b0, 1'b0, n, busy_cyc);
    check("b2b op2 latency", 32'(n), 32'(NBYTES));
    @(posedge clk); #1;

    // Asynchronous reset after two byte edges.
    bus.start = 1'b1; bus.op_sub = 1'b0; bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrun busy", 32'(bus.busy), 32'd1);
    check("midrun partial", bus.result, 32'h0000_FFFE);
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("after_reset", 1'b0, 32'h1234_5678, 32'h1111_1111,
           '{r: 32'h2345_6789, c: 1'b0, v: 1'b0}, 1'b0);

    repeat (8) @(posedge clk);
    #1;
    check("done_count", 32'(n_done), 32'(n_exp_done));
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Multi-cycle controller that performs NBYTES-wide add or subtract by sequencing a single 8-bit carry-chained byte adder, one byte per clock, LSB first. Operands are captured on a start handshake, the carry is registered between byte steps, and result/flags are held until the next operation. Sits between the control unit and the shared byte adder, trading latency for area versus a full-width ripple adder.

## Interface
- NBYTES, 4, operand width in bytes (≥2); W = 8*NBYTES
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- op_sub  in  1  0 = A+B, 1 = A−B; captured with start
- a  in  W  operand A; captured with start
- b  in  W  operand B; captured with start
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse, result valid
- result  out  W  sum/difference; held until next accepted start
- carry_out  out  1  final carry (sub: 1 = no borrow)
- overflow  out  1  signed two's-complement overflow

## Operation
- States: IDLE, RUN, DONE. IDLE --start--> RUN; RUN --last byte--> DONE; DONE --> IDLE unconditionally.
- On accept: latch a into op_a, b into op_b (inverted if op_sub), carry register = op_sub, byte index = 0, result register cleared.
- RUN, each cycle: slice adds op_a[idx], op_b'[idx], carry; sum written to result[8*idx +: 8], carry register updated, idx increments. idx wraps only via state exit; at idx = NBYTES−1 state moves to DONE.
- Last byte: carry_out = slice carry out; overflow = (op_a MSB == op_b' MSB) && (sum MSB != op_a MSB).
- start ignored in RUN and DONE (no queueing); op_sub/a/b changes after acceptance have no effect.
- Reset (any state, including mid-RUN): state IDLE, busy=0, done=0, result=0, carry_out=0, overflow=0, internal registers 0. Partial results are discarded.

## Timing
- Start accepted on edge E0 (state IDLE, start=1). Bytes processed on edges E1..E_NBYTES; done=1 for the cycle following E_NBYTES. Latency start edge → done = NBYTES+1 edges (5 for NBYTES=4).
- busy asserts the cycle after E0 and deasserts the cycle after E_NBYTES.
- Earliest next acceptance: the edge after the DONE cycle (NBYTES+2 edges per operation).
- result bytes update progressively during RUN. They are valid only when done=1 and are stable afterward. Flags change only on the last byte edge and on acceptance, where they are cleared.
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Shared package: state encoding (IDLE, RUN, DONE) and the byte-width constant (8).
- One sub-module: byte_add_slice (8-bit a, b, cin → 8-bit s, cout), purely combinational, instantiated once. The FSM, index counter, carry register, operand registers and result register live in wide_add_sequencer.

## Test plan
- Reset: hold rst_n=0 with random inputs → busy=0, done=0, result=0, carry_out=0, overflow=0; start during reset ignored.
- Add, no carry: a=0x000000AA, b=0x00000054, op_sub=0 → done exactly 5 edges after start, result=0x000000FE, carry_out=0, overflow=0; busy high 4 cycles.
- Full carry ripple: a=0xFFFFFFFF, b=0x00000001 → result=0x00000000, carry_out=1, overflow=0. Also a=0x7FFFFFFF, b=1 → result=0x80000000, carry_out=0, overflow=1.
- Subtract: a=0x00000000, b=0x00000001, op_sub=1 → result=0xFFFFFFFF, carry_out=0, overflow=0. Also a=0x80000000, b=1, op_sub=1 → result=0x7FFFFFFF, carry_out=1, overflow=1.
- Handshake robustness: pulse start with different operands during RUN and DONE, and change a/b mid-RUN → the first operation's result is unaffected and no extra done pulse occurs. Back-to-back starts → second op accepted the edge after DONE.
- Reset mid-operation: assert rst_n=0 after 2 byte edges → all outputs 0 immediately (asynchronous). After release, a=0x12345678 + b=0x11111111 → result=0x23456789, carry_out=0.
